// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state encoding and default timing for the SRAM controller
package sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR,
    ST_WR_HOLD,
    ST_TURN
  } sram_state_t;

  localparam int DEF_ADDR_WIDTH = 20;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_READ_WAIT  = 2;
  localparam int DEF_WRITE_WAIT = 2;
  localparam int DEF_TURN_WAIT  = 1;

  // Counter wide enough to hold the largest wait load without wrapping.
  function automatic int cnt_width(input int rw, input int ww, input int tw);
    int m;
    m = rw;
    if (ww > m) m = ww;
    if (tw > m) m = tw;
    return $clog2(m + 2);
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// rtl/sram_ctrl_if.sv - master-side request/response bundle of the SRAM controller
interface sram_ctrl_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);

  logic [ADDR_WIDTH-1:0] address;
  logic [BE_WIDTH-1:0]   byteenable;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdataready;
  logic                  waitrequest;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, readdataready, waitrequest
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, readdataready, waitrequest
  );

endinterface

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-port asynchronous SRAM controller with programmable strobe timing
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int READ_WAIT  = DEF_READ_WAIT,
  parameter int WRITE_WAIT = DEF_WRITE_WAIT,
  parameter int TURN_WAIT  = DEF_TURN_WAIT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  sram_ctrl_if.slave            bus,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_dq_out,
  output logic                  sram_dq_oe,
  input  logic [DATA_WIDTH-1:0] sram_dq_in,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_lb_n,
  output logic                  sram_ub_n
);

  localparam int CW = cnt_width(READ_WAIT, WRITE_WAIT, TURN_WAIT);

  sram_state_t           state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] readdata_q;
  logic                  readdataready_q;

  // Only IDLE accepts a request; every other state stalls the master.
  assign bus.waitrequest   = (state != ST_IDLE);
  assign bus.readdata      = readdata_q;
  assign bus.readdataready = readdataready_q;

  // Access sequencer: state, wait counter and every SRAM pin are registered here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      readdata_q      <= '0;
      readdataready_q <= 1'b0;
      sram_addr       <= '0;
      sram_dq_out     <= '0;
      sram_dq_oe      <= 1'b0;
      sram_ce_n       <= 1'b1;
      sram_oe_n       <= 1'b1;
      sram_we_n       <= 1'b1;
      sram_lb_n       <= 1'b1;
      sram_ub_n       <= 1'b1;
    end else begin
      readdataready_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Write wins over a simultaneous read; the read is simply dropped.
          if (bus.write) begin
            state       <= ST_WR_SETUP;
            sram_addr   <= bus.address;
            sram_dq_out <= bus.writedata;
            sram_dq_oe  <= 1'b1;
            sram_ce_n   <= 1'b0;
            sram_lb_n   <= ~bus.byteenable[0];
            sram_ub_n   <= ~bus.byteenable[1];
          end else if (bus.read) begin
            state     <= ST_RD;
            cnt       <= CW'(READ_WAIT);
            sram_addr <= bus.address;
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            sram_lb_n <= ~bus.byteenable[0];
            sram_ub_n <= ~bus.byteenable[1];
          end
        end
        ST_RD: begin
          if (cnt == '0) begin
            state           <= ST_IDLE;
            readdata_q      <= sram_dq_in;
            readdataready_q <= 1'b1;
            sram_ce_n       <= 1'b1;
            sram_oe_n       <= 1'b1;
            sram_lb_n       <= 1'b1;
            sram_ub_n       <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WR_SETUP: begin
          state     <= ST_WR;
          cnt       <= CW'(WRITE_WAIT);
          sram_we_n <= 1'b0;
        end
        ST_WR: begin
          if (cnt == '0) begin
            state     <= ST_WR_HOLD;
            sram_we_n <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WR_HOLD: begin
          sram_ce_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          sram_lb_n  <= 1'b1;
          sram_ub_n  <= 1'b1;
          if (TURN_WAIT == 0) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_TURN;
            cnt   <= CW'(TURN_WAIT - 1);
          end
        end
        ST_TURN: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed self-checking bench for sram_ctrl
module tb_sram_ctrl;

  logic clock;
  logic reset_n;

  sram_ctrl_if #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .BE_WIDTH(2)) bus ();
  sram_ctrl_if #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .BE_WIDTH(2)) bus0 ();

  logic [19:0] sram_addr, sram_addr0;
  logic [15:0] sram_dq_out, sram_dq_out0;
  logic [15:0] sram_dq_in, sram_dq_in0;
  logic sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
  logic sram_dq_oe0, sram_ce_n0, sram_oe_n0, sram_we_n0, sram_lb_n0, sram_ub_n0;

  sram_ctrl u_dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  sram_ctrl #(.READ_WAIT(0), .WRITE_WAIT(0), .TURN_WAIT(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .bus(bus0),
    .sram_addr(sram_addr0), .sram_dq_out(sram_dq_out0), .sram_dq_oe(sram_dq_oe0),
    .sram_dq_in(sram_dq_in0), .sram_ce_n(sram_ce_n0), .sram_oe_n(sram_oe_n0),
    .sram_we_n(sram_we_n0), .sram_lb_n(sram_lb_n0), .sram_ub_n(sram_ub_n0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int viol   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Bus-contention and unsafe-write watch on both instances.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if ((sram_dq_oe === 1'b1 && sram_oe_n === 1'b0) || (sram_we_n === 1'b0 && sram_dq_oe !== 1'b1) ||
          (sram_dq_oe0 === 1'b1 && sram_oe_n0 === 1'b0) || (sram_we_n0 === 1'b0 && sram_dq_oe0 !== 1'b1)) begin
        viol++;
        $display("FAIL contention at %0t: dq_oe=%b oe_n=%b we_n=%b dq_oe0=%b oe_n0=%b we_n0=%b",
                 $time, sram_dq_oe, sram_oe_n, sram_we_n, sram_dq_oe0, sram_oe_n0, sram_we_n0);
      end
    end
  end

  logic [7:0] we_tab, oe_tab, ce_tab, wait_tab;

  initial begin
    reset_n = 1'b0;
    bus.address = '0; bus.byteenable = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    bus0.address = '0; bus0.byteenable = '0; bus0.read = 1'b0; bus0.write = 1'b0; bus0.writedata = '0;
    sram_dq_in = '0;
    sram_dq_in0 = '0;
    // Expected per-cycle write waveforms, bit c = cycle c after acceptance.
    we_tab   = 8'b1110_0010;
    oe_tab   = 8'b0011_1110;
    ce_tab   = 8'b1100_0000;
    wait_tab = 8'b0111_1110;

    step();
    step();
    check("rst_wait", bus.waitrequest, 0);
    check("rst_rdr", bus.readdataready, 0);
    check("rst_rdata", bus.readdata, 0);
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 5'b11111);
    check("rst_dq_oe", sram_dq_oe, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_dq_out", sram_dq_out, 0);
    reset_n = 1'b1;
    step();

    // Single read at defaults.
    bus.address = 20'h12345; bus.byteenable = 2'b11; bus.read = 1'b1; sram_dq_in = 16'hBEEF;
    check("rd_c0_wait", bus.waitrequest, 0);
    for (int c = 1; c <= 3; c++) begin
      step();
      check($sformatf("rd_c%0d_ce_oe", c), {sram_ce_n, sram_oe_n}, 2'b00);
      check($sformatf("rd_c%0d_dq_oe", c), sram_dq_oe, 0);
      check($sformatf("rd_c%0d_wait", c), bus.waitrequest, 1);
      check($sformatf("rd_c%0d_rdr", c), bus.readdataready, 0);
      check($sformatf("rd_c%0d_addr", c), sram_addr, 20'h12345);
    end
    step();
    check("rd_c4_rdr", bus.readdataready, 1);
    check("rd_c4_rdata", bus.readdata, 16'hBEEF);
    check("rd_c4_oe_n", sram_oe_n, 1);
    check("rd_c4_wait", bus.waitrequest, 0);
    bus.read = 1'b0;
    step();
    check("rd_c5_rdr", bus.readdataready, 0);

    // Single write, low lane only.
    bus.address = 20'h00010; bus.byteenable = 2'b01; bus.write = 1'b1; bus.writedata = 16'hA5A5;
    for (int c = 1; c <= 7; c++) begin
      step();
      check($sformatf("wr_c%0d_we_n", c), sram_we_n, we_tab[c]);
      check($sformatf("wr_c%0d_dq_oe", c), sram_dq_oe, oe_tab[c]);
      check($sformatf("wr_c%0d_ce_n", c), sram_ce_n, ce_tab[c]);
      check($sformatf("wr_c%0d_wait", c), bus.waitrequest, wait_tab[c]);
      check($sformatf("wr_c%0d_oe_n", c), sram_oe_n, 1);
      if (c <= 5) begin
        check($sformatf("wr_c%0d_lanes", c), {sram_lb_n, sram_ub_n}, 2'b01);
        check($sformatf("wr_c%0d_data", c), {sram_addr, sram_dq_out}, {20'h00010, 16'hA5A5});
      end
    end
    bus.write = 1'b0;

    // Read and write together: the write runs, the read is dropped.
    bus.address = 20'h4; bus.byteenable = 2'b11; bus.read = 1'b1; bus.write = 1'b1; bus.writedata = 16'h1234;
    for (int c = 1; c <= 7; c++) begin
      step();
      check($sformatf("rw_c%0d_we_n", c), sram_we_n, we_tab[c]);
      check($sformatf("rw_c%0d_wait", c), bus.waitrequest, wait_tab[c]);
      check($sformatf("rw_c%0d_rdr", c), bus.readdataready, 0);
    end
    bus.read = 1'b0; bus.write = 1'b0;
    step();
    check("rw_c8_rdr", bus.readdataready, 0);

    // Back-to-back reads with read held high.
    bus.address = 20'h20; bus.read = 1'b1; sram_dq_in = 16'h1111;
    for (int c = 1; c <= 8; c++) begin
      step();
      check($sformatf("b2b_c%0d_rdr", c), bus.readdataready, (c == 4 || c == 8) ? 1 : 0);
      check($sformatf("b2b_c%0d_wait", c), bus.waitrequest, (c == 4 || c == 8) ? 0 : 1);
      if (c == 4) begin
        check("b2b_c4_rdata", bus.readdata, 16'h1111);
        sram_dq_in = 16'h2222;
      end
      if (c == 8) begin
        check("b2b_c8_rdata", bus.readdata, 16'h2222);
        bus.read = 1'b0;
      end
    end

    // Reset in the middle of a write pulse.
    bus.address = 20'h30; bus.write = 1'b1; bus.writedata = 16'hCAFE;
    step();
    step();
    step();
    check("rst_wr_c3_we_n", sram_we_n, 0);
    reset_n = 1'b0;
    #1;
    check("rst_wr_we_n", sram_we_n, 1);
    check("rst_wr_dq_oe", sram_dq_oe, 0);
    check("rst_wr_ce_n", sram_ce_n, 1);
    check("rst_wr_wait", bus.waitrequest, 0);
    bus.write = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_wait", bus.waitrequest, 0);
    check("post_rst_rdr", bus.readdataready, 0);
    bus.address = 20'h40; bus.read = 1'b1; sram_dq_in = 16'h5A5A;
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("post_rst_c%0d_rdr", c), bus.readdataready, (c == 4) ? 1 : 0);
    end
    check("post_rst_rdata", bus.readdata, 16'h5A5A);
    bus.read = 1'b0;

    // Zero-wait instance: shortest read, and a write with no lanes and no turnaround.
    bus0.address = 20'h5; bus0.byteenable = 2'b11; bus0.read = 1'b1; sram_dq_in0 = 16'h7777;
    step();
    check("z_rd_c1_oe_n", sram_oe_n0, 0);
    check("z_rd_c1_wait", bus0.waitrequest, 1);
    step();
    check("z_rd_c2_rdr", bus0.readdataready, 1);
    check("z_rd_c2_rdata", bus0.readdata, 16'h7777);
    check("z_rd_c2_wait", bus0.waitrequest, 0);
    bus0.read = 1'b0;
    bus0.address = 20'h6; bus0.byteenable = 2'b00; bus0.write = 1'b1; bus0.writedata = 16'h0F0F;
    step();
    check("z_wr_c1", {sram_we_n0, sram_dq_oe0, sram_ce_n0}, 3'b110);
    step();
    check("z_wr_c2_we_n", sram_we_n0, 0);
    check("z_wr_c2_lanes", {sram_lb_n0, sram_ub_n0}, 2'b11);
    step();
    check("z_wr_c3", {sram_we_n0, sram_dq_oe0, bus0.waitrequest}, 3'b111);
    step();
    check("z_wr_c4_wait", bus0.waitrequest, 0);
    check("z_wr_c4_ce_n", sram_ce_n0, 1);
    bus0.write = 1'b0;
    step();

    check("no_contention", viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data width.
REQ-003 SHALL have parameter BE_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-004 SHALL have parameter READ_WAIT, default 2, extra read strobe cycles (read strobe = READ_WAIT+1 cycles).
REQ-005 SHALL have parameter WRITE_WAIT, default 2, extra write-pulse cycles (we_n low = WRITE_WAIT+1 cycles).
REQ-006 SHALL have parameter TURN_WAIT, default 1, idle bus cycles after each write.
REQ-007 SHALL have one clock and an asynchronous active-low reset: clock  in  1  sole clock; reset_n  in  1  asynchronous active-low reset.
REQ-008 Master side: address  in  ADDR_WIDTH  word address; byteenable  in  BE_WIDTH  lane enables; read  in  1  read request; write  in  1  write request; writedata  in  DATA_WIDTH  write data.
REQ-009 Master side: readdata  out  DATA_WIDTH  read result; readdataready  out  1  one-cycle read-valid pulse; waitrequest  out  1  request not accepted.
REQ-010 SRAM side: sram_addr  out  ADDR_WIDTH; sram_dq_out  out  DATA_WIDTH; sram_dq_oe  out  1  drive enable; sram_dq_in  in  DATA_WIDTH; sram_ce_n, sram_oe_n, sram_we_n  out  1 each; sram_lb_n, sram_ub_n  out  1 each, lane selects (BE_WIDTH=2).

Function
REQ-011 SHALL implement FSM states IDLE, RD, WR_SETUP, WR, WR_HOLD, TURN; waitrequest SHALL equal 1 in every state except IDLE.
REQ-012 A request SHALL be accepted on a cycle with state IDLE and (read or write) high; address, byteenable, writedata SHALL be registered at acceptance.
REQ-013 Master SHALL hold read/write/address/data stable while waitrequest is high; block SHALL ignore inputs outside IDLE.
REQ-014 Simultaneous read and write in IDLE: write SHALL be performed, read SHALL be dropped with no readdataready.
REQ-015 Read: accept at cycle 0; cycles 1..READ_WAIT+1 state RD, ce_n=oe_n=0, dq_oe=0; sram_dq_in SHALL be captured at the end of the last RD cycle.
REQ-016 Read: state IDLE at cycle READ_WAIT+2 with readdataready=1 and readdata valid for exactly that cycle; a new request MAY be accepted in that same cycle.
REQ-017 Write: cycle 1 WR_SETUP (ce_n=0, we_n=1, dq_oe=1); cycles 2..WRITE_WAIT+2 WR (we_n=0); next cycle WR_HOLD (we_n=1, dq_oe=1, ce_n=0); then TURN_WAIT cycles TURN with all strobes high and dq_oe=0; then IDLE.
REQ-018 With TURN_WAIT=0, TURN SHALL be skipped; WR_HOLD SHALL go directly to IDLE.
REQ-019 lb_n = ~byteenable[0], ub_n = ~byteenable[1], valid from cycle 1 to end of access; byteenable=0 SHALL still run the full timing sequence with both lanes high.
REQ-020 sram_dq_oe SHALL never be high in any cycle where sram_oe_n is low.
REQ-021 A single down-counter of width clog2(max(READ_WAIT,WRITE_WAIT,TURN_WAIT)+2) SHALL time RD, WR, TURN; no wrap-around permitted.
REQ-022 All SRAM-side outputs and readdataready SHALL be registered (glitch-free).

Reset
REQ-023 On reset_n low, asynchronously: state IDLE, counter 0, readdataready 0, readdata 0, sram_ce_n/oe_n/we_n/lb_n/ub_n 1, sram_dq_oe 0, sram_addr 0, sram_dq_out 0; waitrequest 0.
REQ-024 Reset mid-access SHALL abort it: no readdataready pulse, we_n deasserted immediately.

Structure
REQ-025 State encoding and default timing constants SHALL reside in shared package sram_pkg.
REQ-026 No sub-module; counter and FSM SHALL be inline.

Verification
REQ-027 Read, defaults, address 0x12345, sram_dq_in=0xBEEF -> oe_n low cycles 1-3, readdataready=1 with readdata=0xBEEF at cycle 4 only.
REQ-028 Write 0xA5A5 to 0x00010, byteenable=2'b01 -> we_n low cycles 2-4, lb_n=0, ub_n=1, dq_oe high cycles 1-5, waitrequest low again at cycle 7.
REQ-029 Read and write asserted together, address 0x4 -> write sequence only, no readdataready.
REQ-030 Back-to-back reads held high -> accepts at cycles 0 and 4, readdataready at 4 and 8.
REQ-031 reset_n low at cycle 3 of a write -> we_n=1, dq_oe=0 immediately; after release, waitrequest=0 and next read completes normally.
REQ-032 Assertion over all tests: never (sram_dq_oe & ~sram_oe_n); never (sram_we_n low & ~sram_dq_oe).
